fsm_pulse_seq_param: RTL and testbench

//  Parametrised successor of the two-input pulse-driven route FSM.
//  - Samples NUM_IN pulse input channels on each GCLK_Pad rising edge.
//  - Tracks progress through a programmable event sequence of SEQ_LEN steps.
//  - On completion: raises a match pulse or latch and counts completed matches.
//  - Exposes the state encoding for observation, like the state_obs pads of the 2-bit FSM.

---
 rtl/fsm_pulse_seq_param_if.sv | 31 +++
 rtl/fsm_pulse_seq_param.sv | 109 ++++++++++
 tb/tb_fsm_pulse_seq_param.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fsm_pulse_seq_param_if.sv
// Pad bundle for the parametrised pulse-sequence FSM: one event input
// vector plus the registered observation/match outputs.
interface fsm_pulse_seq_param_if #(
  parameter int NUM_IN  = 2,
  parameter int SEQ_LEN = 3,
  parameter int CNT_W   = 4
);
  localparam int SW = $clog2(SEQ_LEN + 1);

  logic [NUM_IN-1:0] input_Pad;
  logic [SW-1:0]     state_obs_Pad;
  logic              output1_Pad;
  logic              mismatch_Pad;
  logic [CNT_W-1:0]  match_cnt_Pad;

  modport master (
    output input_Pad,
    input  state_obs_Pad,
    input  output1_Pad,
    input  mismatch_Pad,
    input  match_cnt_Pad
  );

  modport slave (
    input  input_Pad,
    output state_obs_Pad,
    output output1_Pad,
    output mismatch_Pad,
    output match_cnt_Pad
  );
endinterface

// File: rtl/fsm_pulse_seq_param.sv
// Programmable pulse-sequence detector: walks SEQ_LEN exact-match event masks,
// flags wrong events, and counts completed matches (restart or latch mode).
module fsm_pulse_seq_param #(
  parameter int                          NUM_IN      = 2,
  parameter int                          SEQ_LEN     = 3,
  parameter logic [NUM_IN*SEQ_LEN-1:0]   SEQ_PATTERN = 6'b111001,
  parameter int                          MODE        = 0,
  parameter int                          CNT_W       = 4
) (
  input logic                  GCLK_Pad,
  input logic                  reset_Pad,
  fsm_pulse_seq_param_if.slave bus
);
  localparam int SW = $clog2(SEQ_LEN + 1);

  typedef enum logic [SW-1:0] {
    S_START = '0,
    S_DONE  = SW'(SEQ_LEN)
  } state_e;

  logic [NUM_IN-1:0] step_mask [SEQ_LEN];

  generate
    if (NUM_IN < 1 || SEQ_LEN < 2) begin : g_bad_size
      $error("fsm_pulse_seq_param: NUM_IN must be >= 1 and SEQ_LEN >= 2");
    end
    for (genvar gi = 0; gi < SEQ_LEN; gi++) begin : g_step
      if (SEQ_PATTERN[gi*NUM_IN +: NUM_IN] == '0) begin : g_zero_step
        $error("fsm_pulse_seq_param: step mask %0d is zero", gi);
      end
      assign step_mask[gi] = SEQ_PATTERN[gi*NUM_IN +: NUM_IN];
    end
  endgenerate

  state_e           state_q, state_d;
  logic             out1_q, out1_d;
  logic             mism_q, mism_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_IN-1:0] ev;
  logic [NUM_IN-1:0] cur_step;
  logic              state_legal;
  logic              is_done;
  logic              is_last;

  assign ev = bus.input_Pad;

  // Mux instead of direct indexing so an illegal state never reads out of range.
  always_comb begin
    cur_step = step_mask[0];
    for (int i = 1; i < SEQ_LEN; i++) begin
      if (state_q == SW'(i)) begin
        cur_step = step_mask[i];
      end
    end
  end

  assign is_done     = (MODE != 0) && (state_q == S_DONE);
  assign is_last     = (state_q == SW'(SEQ_LEN - 1));
  assign state_legal = (MODE != 0) ? (state_q <= S_DONE) : (state_q < S_DONE);

  always_comb begin
    state_d = state_q;
    out1_d  = 1'b0;
    mism_d  = 1'b0;
    cnt_d   = cnt_q;

    if (!state_legal) begin
      state_d = S_START;
    end else if (is_done) begin
      out1_d = 1'b1;
    end else if (ev != '0) begin
      if (ev == cur_step) begin
        if (is_last) begin
          out1_d  = 1'b1;
          state_d = (MODE != 0) ? S_DONE : S_START;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = state_e'(state_q + 1'b1);
        end
      end else begin
        // A wrong event that is itself the first step restarts at step 1.
        mism_d  = 1'b1;
        state_d = (ev == step_mask[0]) ? state_e'(SW'(1)) : S_START;
      end
    end
  end

  always_ff @(posedge GCLK_Pad) begin
    if (!reset_Pad) begin
      state_q <= S_START;
      out1_q  <= 1'b0;
      mism_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out1_q  <= out1_d;
      mism_q  <= mism_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.state_obs_Pad = state_q;
  assign bus.output1_Pad   = out1_q;
  assign bus.mismatch_Pad  = mism_q;
  assign bus.match_cnt_Pad = cnt_q;
endmodule

// File: tb/tb_fsm_pulse_seq_param.sv
// Directed bench: three instances (restart mode, latch mode, 2-bit counter)
// driven from one stimulus thread with hand-computed expectations.
module tb_fsm_pulse_seq_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  fsm_pulse_seq_param_if #(.NUM_IN(2), .SEQ_LEN(3), .CNT_W(4)) if0 ();
  fsm_pulse_seq_param_if #(.NUM_IN(2), .SEQ_LEN(3), .CNT_W(4)) if1 ();
  fsm_pulse_seq_param_if #(.NUM_IN(2), .SEQ_LEN(3), .CNT_W(2)) if2 ();

  fsm_pulse_seq_param #(
    .NUM_IN(2), .SEQ_LEN(3), .SEQ_PATTERN(6'b111001), .MODE(0), .CNT_W(4)
  ) dut0 (.GCLK_Pad(clk), .reset_Pad(rst_n), .bus(if0.slave));

  fsm_pulse_seq_param #(
    .NUM_IN(2), .SEQ_LEN(3), .SEQ_PATTERN(6'b111001), .MODE(1), .CNT_W(4)
  ) dut1 (.GCLK_Pad(clk), .reset_Pad(rst_n), .bus(if1.slave));

  fsm_pulse_seq_param #(
    .NUM_IN(2), .SEQ_LEN(3), .SEQ_PATTERN(6'b111001), .MODE(0), .CNT_W(2)
  ) dut2 (.GCLK_Pad(clk), .reset_Pad(rst_n), .bus(if2.slave));

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One transaction: inputs set on the falling edge, outputs sampled 1 time unit after the rising edge.
  task automatic apply(input logic r, input logic [1:0] e0, input logic [1:0] e1,
                       input logic [1:0] e2);
    @(negedge clk);
    rst_n = r;
    if0.input_Pad = e0;
    if1.input_Pad = e1;
    if2.input_Pad = e2;
    @(posedge clk);
    #1;
    $display("[TB] t=%0t rst_n=%b ev=%b/%b/%b | d0 s=%0d o=%b m=%b c=%0d | d1 s=%0d o=%b m=%b c=%0d | d2 s=%0d o=%b m=%b c=%0d",
             $time, r, e0, e1, e2,
             if0.state_obs_Pad, if0.output1_Pad, if0.mismatch_Pad, if0.match_cnt_Pad,
             if1.state_obs_Pad, if1.output1_Pad, if1.mismatch_Pad, if1.match_cnt_Pad,
             if2.state_obs_Pad, if2.output1_Pad, if2.mismatch_Pad, if2.match_cnt_Pad);
  endtask

  task automatic expect_dut(input string tag, input int which, input int st, input int o1,
                            input int mm, input int cnt);
    case (which)
      0: begin
        check({tag, ".state"}, int'(if0.state_obs_Pad), st);
        check({tag, ".out1"},  int'(if0.output1_Pad),   o1);
        check({tag, ".mism"},  int'(if0.mismatch_Pad),  mm);
        check({tag, ".cnt"},   int'(if0.match_cnt_Pad), cnt);
      end
      1: begin
        check({tag, ".state"}, int'(if1.state_obs_Pad), st);
        check({tag, ".out1"},  int'(if1.output1_Pad),   o1);
        check({tag, ".mism"},  int'(if1.mismatch_Pad),  mm);
        check({tag, ".cnt"},   int'(if1.match_cnt_Pad), cnt);
      end
      default: begin
        check({tag, ".state"}, int'(if2.state_obs_Pad), st);
        check({tag, ".out1"},  int'(if2.output1_Pad),   o1);
        check({tag, ".mism"},  int'(if2.mismatch_Pad),  mm);
        check({tag, ".cnt"},   int'(if2.match_cnt_Pad), cnt);
      end
    endcase
  endtask

  initial begin
    int cnt_exp [5];
    cnt_exp = '{1, 2, 3, 3, 3};
    if0.input_Pad = '0;
    if1.input_Pad = '0;
    if2.input_Pad = '0;

    // Test 1: random activity, then a single reset edge clears everything
    apply(1'b0, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    apply(1'b0, 2'b11, 2'b10, 2'b01);
    expect_dut("rst0", 0, 0, 0, 0, 0);
    expect_dut("rst1", 1, 0, 0, 0, 0);
    expect_dut("rst2", 2, 0, 0, 0, 0);

    // Test 2: straight match on the restart-mode instance
    apply(1'b1, 2'b01, 2'b00, 2'b00); expect_dut("m_e1", 0, 1, 0, 0, 0);
    apply(1'b1, 2'b10, 2'b00, 2'b00); expect_dut("m_e2", 0, 2, 0, 0, 0);
    apply(1'b1, 2'b11, 2'b00, 2'b00); expect_dut("m_e3", 0, 0, 1, 0, 1);
    apply(1'b1, 2'b00, 2'b00, 2'b00); expect_dut("m_idle", 0, 0, 0, 0, 1);

    // Test 3: idle gaps inside the sequence
    apply(1'b0, 2'b00, 2'b00, 2'b00);
    apply(1'b1, 2'b01, 2'b00, 2'b00); expect_dut("g1", 0, 1, 0, 0, 0);
    apply(1'b1, 2'b00, 2'b00, 2'b00); expect_dut("g2", 0, 1, 0, 0, 0);
    apply(1'b1, 2'b00, 2'b00, 2'b00); expect_dut("g3", 0, 1, 0, 0, 0);
    apply(1'b1, 2'b10, 2'b00, 2'b00); expect_dut("g4", 0, 2, 0, 0, 0);
    apply(1'b1, 2'b00, 2'b00, 2'b00); expect_dut("g5", 0, 2, 0, 0, 0);
    apply(1'b1, 2'b11, 2'b00, 2'b00); expect_dut("g6", 0, 0, 1, 0, 1);
    apply(1'b1, 2'b00, 2'b00, 2'b00); expect_dut("g7", 0, 0, 0, 0, 1);

    // Test 4: wrong events
    apply(1'b0, 2'b00, 2'b00, 2'b00);
    apply(1'b1, 2'b01, 2'b00, 2'b00); expect_dut("w1", 0, 1, 0, 0, 0);
    apply(1'b1, 2'b01, 2'b00, 2'b00); expect_dut("w2", 0, 1, 0, 1, 0);
    apply(1'b1, 2'b10, 2'b00, 2'b00); expect_dut("w3", 0, 2, 0, 0, 0);
    apply(1'b1, 2'b01, 2'b00, 2'b00); expect_dut("w4", 0, 1, 0, 1, 0);
    apply(1'b1, 2'b11, 2'b00, 2'b00); expect_dut("w5", 0, 0, 0, 1, 0);
    apply(1'b1, 2'b00, 2'b00, 2'b00); expect_dut("w6", 0, 0, 0, 0, 0);

    // Test 5: latch mode holds DONE and ignores everything until reset
    apply(1'b0, 2'b00, 2'b00, 2'b00);
    apply(1'b1, 2'b00, 2'b01, 2'b00); expect_dut("l1", 1, 1, 0, 0, 0);
    apply(1'b1, 2'b00, 2'b10, 2'b00); expect_dut("l2", 1, 2, 0, 0, 0);
    apply(1'b1, 2'b00, 2'b11, 2'b00); expect_dut("l3", 1, 3, 1, 0, 1);
    apply(1'b1, 2'b00, 2'b01, 2'b00); expect_dut("l4", 1, 3, 1, 0, 1);
    apply(1'b1, 2'b00, 2'b10, 2'b00); expect_dut("l5", 1, 3, 1, 0, 1);
    apply(1'b1, 2'b00, 2'b11, 2'b00); expect_dut("l6", 1, 3, 1, 0, 1);
    apply(1'b1, 2'b00, 2'b10, 2'b00); expect_dut("l7", 1, 3, 1, 0, 1);
    apply(1'b0, 2'b00, 2'b11, 2'b00); expect_dut("l_rst", 1, 0, 0, 0, 0);

    // Test 6: 2-bit counter saturates, then a mid-sequence reset
    apply(1'b1, 2'b00, 2'b00, 2'b00);
    for (int m = 0; m < 5; m++) begin
      apply(1'b1, 2'b00, 2'b00, 2'b01);
      apply(1'b1, 2'b00, 2'b00, 2'b10);
      apply(1'b1, 2'b00, 2'b00, 2'b11);
      expect_dut($sformatf("sat%0d", m), 2, 0, 1, 0, cnt_exp[m]);
    end
    apply(1'b1, 2'b00, 2'b00, 2'b01); expect_dut("mr1", 2, 1, 0, 0, 3);
    apply(1'b1, 2'b00, 2'b00, 2'b10); expect_dut("mr2", 2, 2, 0, 0, 3);
    apply(1'b0, 2'b00, 2'b00, 2'b11); expect_dut("mr_rst", 2, 0, 0, 0, 0);
    apply(1'b1, 2'b00, 2'b00, 2'b00); expect_dut("mr_idle", 2, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
